// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access block.
package dmem_pkg;

  // Access FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_t;

  // Default number of BUSY cycles to wait for an acknowledge
  localparam int DMEM_TIMEOUT_DEFAULT = 16;

  // Width of the BUSY cycle counter (covers timeouts up to 255)
  localparam int DMEM_CNT_W = 8;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// BUSY-cycle counter for the data-memory access FSM.
// The count represents the index of the current BUSY cycle (first cycle = 1),
// so 'clear' loads 1 on the edge that enters BUSY.
module dmem_timeout_cnt
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [DMEM_CNT_W-1:0] LIMIT = DMEM_CNT_W'(TIMEOUT_CYCLES);

  logic [DMEM_CNT_W-1:0] count;

  // Load 1 on BUSY entry, then advance once per BUSY cycle (saturating)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= DMEM_CNT_W'(1);
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LIMIT);

endmodule

// File: rtl/dmem_access.sv
// Data-memory access unit: turns a MEM-stage load/store into a
// request/acknowledge handshake with a bounded wait and pipeline stall.
// Optional feature: define DMEM_MISALIGN_CHK_EN to reject misaligned
// accesses with a misalign_o pulse instead of issuing them word-aligned.
module dmem_access
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALU_i,
  input  logic [31:0] forward_b_data_i,
  input  logic        MemR_i,
  input  logic        MemW_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        err_o,
  output logic        misalign_o
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  dmem_state_t state;
  logic        access;
  logic        misaligned;
  logic        start;
  logic        busy;
  logic        expired;

  assign access = MemR_i | MemW_i;

`ifdef DMEM_MISALIGN_CHK_EN
  assign misaligned = |ALU_i[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign start = (state == ST_IDLE) && access && !misaligned;
  assign busy  = (state == ST_BUSY);

  // Reset gates the stall so every output reads 0 while rst_n is low
  assign stall_o = rst_n && (start || busy);

  dmem_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start),
    .en     (busy),
    .expired(expired)
  );

  // Access FSM with registered bus outputs; ack takes priority over timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      rdata_valid_o <= 1'b0;
      err_o         <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_BUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= MemW_i;
            mem_addr_o  <= ALU_i & WORD_MASK;
            mem_wdata_o <= forward_b_data_i;
          end
        end
        ST_BUSY: begin
          if (mem_ack_i || expired) begin
            if (mem_ack_i) begin
              if (!mem_we_o) begin
                rdata_o       <= mem_rdata_i;
                rdata_valid_o <= 1'b1;
              end
            end else begin
              err_o <= 1'b1;
            end
            state       <= ST_DONE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_MISALIGN_CHK_EN
  logic misalign_q;

  // One registered pulse per misaligned access seen in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= (state == ST_IDLE) && access && misaligned;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access.sv
// Self-checking bench for dmem_access: directed access sequence with a
// request scoreboard and a response scoreboard.
module tb_dmem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALU_i;
  logic [31:0] forward_b_data_i;
  logic        MemR_i;
  logic        MemW_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        err_o;
  logic        misalign_o;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t cur_req;

  int   errors = 0;
  int   checks = 0;
  int   stall_n, valid_n, err_n, req_n, mis_n;
  logic prev_req;

  always #5 clk = ~clk;

  dmem_access #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ALU_i           (ALU_i),
    .forward_b_data_i(forward_b_data_i),
    .MemR_i          (MemR_i),
    .MemW_i          (MemW_i),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_ack_i       (mem_ack_i),
    .mem_rdata_i     (mem_rdata_i),
    .stall_o         (stall_o),
    .rdata_o         (rdata_o),
    .rdata_valid_o   (rdata_valid_o),
    .err_o           (err_o),
    .misalign_o      (misalign_o)
  );

  // Guard against a hung run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] addr,
                               input logic [31:0] data, input logic ack, input logic [31:0] rd);
    MemR_i           = r;
    MemW_i           = w;
    ALU_i            = addr;
    forward_b_data_i = data;
    mem_ack_i        = ack;
    mem_rdata_i      = rd;
  endtask

  task automatic clearCounts();
    stall_n = 0;
    valid_n = 0;
    err_n   = 0;
    req_n   = 0;
    mis_n   = 0;
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_req"},    32'(mem_req_o),     32'd0);
    checkOutput({pfx, "_we"},     32'(mem_we_o),      32'd0);
    checkOutput({pfx, "_addr"},   mem_addr_o,         32'd0);
    checkOutput({pfx, "_wdata"},  mem_wdata_o,        32'd0);
    checkOutput({pfx, "_stall"},  32'(stall_o),       32'd0);
    checkOutput({pfx, "_rdata"},  rdata_o,            32'd0);
    checkOutput({pfx, "_rvalid"}, 32'(rdata_valid_o), 32'd0);
    checkOutput({pfx, "_err"},    32'(err_o),         32'd0);
    checkOutput({pfx, "_mis"},    32'(misalign_o),    32'd0);
  endtask

  // Per-cycle monitor: counts pulses and drains the scoreboards
  task automatic sampleOutputs();
    rsp_t r;
    stall_n += int'(stall_o);
    valid_n += int'(rdata_valid_o);
    err_n   += int'(err_o);
    req_n   += int'(mem_req_o);
    mis_n   += int'(misalign_o);
    if (mem_req_o && !prev_req) begin
      checkOutput("req_expected", 32'(req_q.size() > 0), 32'd1);
      if (req_q.size() > 0) begin
        cur_req = req_q.pop_front();
        checkOutput("req_we",    32'(mem_we_o), 32'(cur_req.we));
        checkOutput("req_addr",  mem_addr_o,    cur_req.addr);
        checkOutput("req_wdata", mem_wdata_o,   cur_req.wdata);
      end
    end else if (mem_req_o) begin
      checkOutput("hold_addr", mem_addr_o,    cur_req.addr);
      checkOutput("hold_we",   32'(mem_we_o), 32'(cur_req.we));
    end
    if (rdata_valid_o || err_o) begin
      checkOutput("rsp_expected", 32'(rsp_q.size() > 0), 32'd1);
      if (rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        checkOutput("rsp_err", 32'(err_o), 32'(r.err));
        if (!r.err) checkOutput("rsp_rdata", rdata_o, r.rdata);
      end
    end
    prev_req = mem_req_o;
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] addr,
                      input logic [31:0] data, input logic ack, input logic [31:0] rd);
    @(posedge clk);
    #1;
    applyStimulus(r, w, addr, data, ack, rd);
    #1;
    sampleOutputs();
  endtask

  initial begin
    prev_req = 1'b0;
    cur_req  = '0;
    clearCounts();
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    rst_n = 1'b1;

    $display("[TB] load with ack on third BUSY cycle");
    clearCounts();
    req_q.push_back('{we: 1'b0, addr: 32'h0000_0010, wdata: 32'hAAAA_5555});
    rsp_q.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
    step(1'b1, 1'b0, 32'h0000_0010, 32'hAAAA_5555, 1'b0, 32'd0);
    checkOutput("load_idle_stall", 32'(stall_o), 32'd1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h0BAD_0BAD);
    checkOutput("load_done_stall", 32'(stall_o), 32'd0);
    checkOutput("load_done_req", 32'(mem_req_o), 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h0BAD_0BAD);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("ack_ignored_rdata", rdata_o, 32'hDEAD_BEEF);
    checkOutput("load_stall_cycles", 32'(stall_n), 32'd4);
    checkOutput("load_valid_pulses", 32'(valid_n), 32'd1);
    checkOutput("load_req_cycles", 32'(req_n), 32'd3);
    checkOutput("load_err_pulses", 32'(err_n), 32'd0);

    $display("[TB] store with read and write both requested");
    clearCounts();
    req_q.push_back('{we: 1'b1, addr: 32'h0000_0020, wdata: 32'h1234_5678});
    step(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("store_rdata_kept", rdata_o, 32'hDEAD_BEEF);
    checkOutput("store_valid_pulses", 32'(valid_n), 32'd0);
    checkOutput("store_stall_cycles", 32'(stall_n), 32'd2);
    checkOutput("store_req_cycles", 32'(req_n), 32'd1);

    $display("[TB] load with no ack hits timeout");
    clearCounts();
    req_q.push_back('{we: 1'b0, addr: 32'h0000_0040, wdata: 32'd0});
    rsp_q.push_back('{err: 1'b1, rdata: 32'd0});
    step(1'b1, 1'b0, 32'h0000_0040, 32'd0, 1'b0, 32'd0);
    repeat (TO) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("timeout_done_stall", 32'(stall_o), 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("timeout_req_cycles", 32'(req_n), 32'(TO));
    checkOutput("timeout_err_pulses", 32'(err_n), 32'd1);
    checkOutput("timeout_valid_pulses", 32'(valid_n), 32'd0);
    checkOutput("timeout_rdata_kept", rdata_o, 32'hDEAD_BEEF);

    $display("[TB] ack in the timeout cycle");
    clearCounts();
    req_q.push_back('{we: 1'b0, addr: 32'h0000_0044, wdata: 32'd0});
    rsp_q.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D});
    step(1'b1, 1'b0, 32'h0000_0044, 32'd0, 1'b0, 32'd0);
    repeat (TO - 1) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hCAFE_F00D);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("race_err_pulses", 32'(err_n), 32'd0);
    checkOutput("race_valid_pulses", 32'(valid_n), 32'd1);
    checkOutput("race_rdata", rdata_o, 32'hCAFE_F00D);

    $display("[TB] reset during second BUSY cycle");
    clearCounts();
    req_q.push_back('{we: 1'b0, addr: 32'h0000_0050, wdata: 32'd0});
    step(1'b1, 1'b0, 32'h0000_0050, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    prev_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("postreset_err_pulses", 32'(err_n), 32'd0);
    checkOutput("postreset_req_cycles", 32'(req_n), 32'd1);

    $display("[TB] misaligned load at 0x13");
    clearCounts();
`ifdef DMEM_MISALIGN_CHK_EN
    step(1'b1, 1'b0, 32'h0000_0013, 32'd0, 1'b0, 32'd0);
    checkOutput("mis_idle_stall", 32'(stall_o), 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("mis_pulse", 32'(misalign_o), 32'd1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("mis_pulses", 32'(mis_n), 32'd1);
    checkOutput("mis_req_cycles", 32'(req_n), 32'd0);
    checkOutput("mis_stall_cycles", 32'(stall_n), 32'd0);
`else
    req_q.push_back('{we: 1'b0, addr: 32'h0000_0010, wdata: 32'd0});
    rsp_q.push_back('{err: 1'b0, rdata: 32'h600D_F00D});
    step(1'b1, 1'b0, 32'h0000_0013, 32'd0, 1'b0, 32'd0);
    checkOutput("unaligned_idle_stall", 32'(stall_o), 32'd1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h600D_F00D);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("unaligned_mis_pulses", 32'(mis_n), 32'd0);
    checkOutput("unaligned_req_cycles", 32'(req_n), 32'd1);
    checkOutput("unaligned_valid_pulses", 32'(valid_n), 32'd1);
`endif

    checkOutput("req_queue_drained", 32'(req_q.size()), 32'd0);
    checkOutput("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_access.md
DMEM_ACCESS -- requirements
Module: dmem_access

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, max BUSY cycles awaiting mem_ack_i (range 2..255).
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ALU_i  in  32  byte address from the EX/MEM register.
- forward_b_data_i  in  32  store data from the EX/MEM register.
- MemR_i  in  1  load request.
- MemW_i  in  1  store request.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  word address.
- mem_wdata_o  out  32  write data.
- mem_ack_i  in  1  completion; mem_rdata_i valid in the same cycle.
- mem_rdata_i  in  32  read data.
- stall_o  out  1  hold pipeline.
- rdata_o  out  32  captured load data.
- rdata_valid_o  out  1  load data valid pulse.
- err_o  out  1  timeout pulse.
- misalign_o  out  1  misaligned-access pulse.

Function
REQ-003 SHALL implement FSM IDLE, BUSY, DONE.
REQ-004 IDLE with MemR_i|MemW_i SHALL latch address, data and we (MemW_i), then enter BUSY on the next edge.
REQ-005 IDLE with MemR_i and MemW_i both high SHALL treat the access as a write only.
REQ-006 mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL be registered, driven only in BUSY, and held stable until ack or timeout; all SHALL be 0 otherwise.
REQ-007 BUSY with mem_ack_i SHALL capture mem_rdata_i into rdata_o on reads (rdata_o unchanged on writes), then go to DONE.
REQ-008 BUSY SHALL count cycles from 1; when the count reaches TIMEOUT_CYCLES without ack, the block SHALL pulse err_o for 1 cycle, drop the request and go to DONE.
REQ-009 If ack and timeout occur in the same cycle, ack SHALL win and err_o SHALL stay 0.
REQ-010 DONE SHALL last exactly 1 cycle, assert rdata_valid_o for completed reads, start no new access, then go to IDLE.
REQ-011 stall_o SHALL be combinational: (IDLE and (MemR_i|MemW_i) and not misaligned) or BUSY; it SHALL be 0 in DONE.
REQ-012 Minimum access latency SHALL be 3 cycles (IDLE, BUSY with ack, DONE); load data SHALL appear on rdata_o in DONE.
REQ-013 mem_ack_i SHALL be ignored outside BUSY.

Reset
REQ-014 On rst_n low, all outputs SHALL be 0 and the FSM SHALL be IDLE, asynchronously; an in-flight request SHALL be dropped immediately with no err_o.
REQ-015 After reset release, the first access SHALL start on the first rising edge at which MemR_i|MemW_i is sampled.

Configuration
REQ-016 With DMEM_MISALIGN_CHK_EN defined, an IDLE access with ALU_i[1:0]!=0 SHALL issue no request, SHALL hold stall_o 0, and SHALL pulse misalign_o for 1 cycle registered; the FSM SHALL stay in IDLE.
REQ-017 Without DMEM_MISALIGN_CHK_EN, misalign_o SHALL be tied 0 and mem_addr_o[1:0] SHALL be forced to 0.

Structure
REQ-018 Package dmem_pkg SHALL hold the FSM state enum typedef and the default timeout constant.
REQ-019 The timeout counter SHALL be sub-module dmem_timeout_cnt, with clear on BUSY entry, enable in BUSY, and output expired.

Verification
REQ-020 Load at 0x0000_0010, ack on the 3rd BUSY cycle with rdata 0xDEAD_BEEF -> mem_addr_o 0x10 and we 0; stall_o high for 4 cycles; rdata_o 0xDEAD_BEEF with 1 rdata_valid_o pulse.
REQ-021 Store of 0x1234_5678 to 0x20, with MemR_i and MemW_i both high -> mem_we_o 1, wdata 0x1234_5678, no rdata_valid_o pulse.
REQ-022 Load with no ack and TIMEOUT_CYCLES=4 -> req high for 4 cycles, 1 err_o pulse, DONE, then IDLE.
REQ-023 Ack in the same cycle the count hits TIMEOUT_CYCLES -> rdata captured, err_o 0.
REQ-024 rst_n low for 2nd BUSY cycle -> all outputs 0 at once; IDLE; no err_o.
REQ-025 Load at 0x0000_0013 -> with DMEM_MISALIGN_CHK_EN: misalign_o pulse, no req, stall_o 0; without it: req with mem_addr_o 0x10.
